wm_load_fifo: RTL and testbench

Parametrised weight-load buffer between the weight fetch path and the MAC-array weight registers. It carries weight-load beats (data, shift amount, target row) through a DEPTH-entry first-word-fall-through FIFO with valid/ready handshakes on both sides, so the array can stall weight loading without losing beats. It adds synchronous flush, occupancy reporting and a sticky row-sequence checker. It supersedes the fixed one-stage weight-load pipeline register.

---
 rtl/wm_load_fifo.sv | 121 ++++++++++++
 tb/tb_wm_load_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_load_fifo.sv
// rtl/wm_load_fifo.sv - weight-load FWFT buffer with flush, occupancy and row-sequence checker
//
// Purpose:
//   Buffers weight-load beats {data, shift amount, row} between the weight
//   fetch path and the MAC-array weight registers. DEPTH-entry
//   first-word-fall-through FIFO with valid/ready on both sides.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   FLUSH               synchronous flush (keeps ROW_ERR)
//   WLoad1/WRdy1        upstream valid/ready
//   WDATA1/shamt1/WROW1 upstream beat fields
//   WLoad2/WRdy2        downstream valid/ready
//   WDATA2/shamt2/WROW2 head-entry fields (zero while empty)
//   COUNT               occupancy
//   ROW_ERR             sticky row-sequence error
module wm_load_fifo #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int ROW_W   = 2,
  parameter int ROWS    = 4,
  parameter int DEPTH   = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       FLUSH,
  input  logic                       WLoad1,
  output logic                       WRdy1,
  input  logic [DATA_W-1:0]          WDATA1,
  input  logic [SHAMT_W-1:0]         shamt1,
  input  logic [ROW_W-1:0]           WROW1,
  output logic                       WLoad2,
  input  logic                       WRdy2,
  output logic [DATA_W-1:0]          WDATA2,
  output logic [SHAMT_W-1:0]         shamt2,
  output logic [ROW_W-1:0]           WROW2,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       ROW_ERR
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = DATA_W + SHAMT_W + ROW_W;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [ROW_W-1:0]   exp_row;
  logic               row_err;

  logic               push;
  logic               pop;
  logic [ROW_W-1:0]   next_row;
  logic [ENTRY_W-1:0] head;

  // Handshake flags come only from the registered count, so neither
  // WLoad1 nor WRdy2 reaches any output combinationally.
  assign WRdy1  = (count != FULL_CNT);
  assign WLoad2 = (count != '0);

  assign push = WLoad1 && WRdy1;
  assign pop  = WLoad2 && WRdy2;

  // Expected row follows the received row, so one bad row flags once and
  // the checker then tracks the new sequence.
  assign next_row = (WROW1 == LAST_ROW) ? '0 : WROW1 + ROW_W'(1);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      exp_row <= '0;
      row_err <= 1'b0;
    end else if (FLUSH) begin
      // Any push or pop in the flush cycle is dropped, ROW_ERR is kept.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      exp_row <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        exp_row <= next_row;
        if (WROW1 != exp_row) begin
          row_err <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once counted.
  always_ff @(posedge CLK) begin
    if (push && !RST && !FLUSH) begin
      mem[wr_ptr] <= {WDATA1, shamt1, WROW1};
    end
  end

  // Head is forced to zero while empty so stale entries never leak out.
  assign head = WLoad2 ? mem[rd_ptr] : '0;

  assign WDATA2  = head[ENTRY_W-1 -: DATA_W];
  assign shamt2  = head[ROW_W +: SHAMT_W];
  assign WROW2   = head[ROW_W-1:0];
  assign COUNT   = count;
  assign ROW_ERR = row_err;

endmodule

// File: tb/tb_wm_load_fifo.sv
// tb/tb_wm_load_fifo.sv - self-checking bench for wm_load_fifo against a queue model
module tb_wm_load_fifo;

  localparam int DEPTH = 4;
  localparam int ROWS  = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FLUSH = 1'b0;
  logic        WLoad1 = 1'b0;
  logic        WRdy1;
  logic [31:0] WDATA1 = '0;
  logic [4:0]  shamt1 = '0;
  logic [1:0]  WROW1 = '0;
  logic        WLoad2;
  logic        WRdy2 = 1'b0;
  logic [31:0] WDATA2;
  logic [4:0]  shamt2;
  logic [1:0]  WROW2;
  logic [2:0]  COUNT;
  logic        ROW_ERR;

  wm_load_fifo #(
    .DATA_W(32), .SHAMT_W(5), .ROW_W(2), .ROWS(ROWS), .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .WLoad1(WLoad1), .WRdy1(WRdy1), .WDATA1(WDATA1), .shamt1(shamt1), .WROW1(WROW1),
    .WLoad2(WLoad2), .WRdy2(WRdy2), .WDATA2(WDATA2), .shamt2(shamt2), .WROW2(WROW2),
    .COUNT(COUNT), .ROW_ERR(ROW_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  r;
  } beat_t;

  beat_t q[$];
  logic  m_err = 1'b0;
  int    m_exp = 0;
  int    pushes = 0;
  bit    m_pu;
  bit    m_po;
  bit    checking = 1'b0;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain queue of beats plus the row rule.
  always @(posedge CLK) begin
    if (RST) begin
      q.delete();
      m_err = 1'b0;
      m_exp = 0;
    end else if (FLUSH) begin
      q.delete();
      m_exp = 0;
    end else begin
      m_pu = WLoad1 && (q.size() < DEPTH);
      m_po = WRdy2 && (q.size() > 0);
      if (m_po) void'(q.pop_front());
      if (m_pu) begin
        if (int'(WROW1) != m_exp) m_err = 1'b1;
        m_exp = (int'(WROW1) == ROWS - 1) ? 0 : int'(WROW1) + 1;
        q.push_back('{d: WDATA1, s: shamt1, r: WROW1});
        pushes++;
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge CLK) begin
    beat_t h;
    if (checking) begin
      h = (q.size() > 0) ? q[0] : '0;
      chk("WRdy1",   WRdy1,   q.size() != DEPTH);
      chk("WLoad2",  WLoad2,  q.size() != 0);
      chk("COUNT",   COUNT,   q.size());
      chk("WDATA2",  WDATA2,  h.d);
      chk("shamt2",  shamt2,  h.s);
      chk("WROW2",   WROW2,   h.r);
      chk("ROW_ERR", ROW_ERR, m_err);
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input int row);
    WLoad1 = 1'b1;
    WDATA1 = d;
    shamt1 = 5'($urandom);
    WROW1  = 2'(row);
  endtask

  logic [31:0] pass_d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  int base;
  logic [31:0] sd;
  logic [4:0]  ss;
  logic [1:0]  sr;
  int rows_e [4] = '{0, 1, 3, 0};

  initial begin
    RST = 1'b1;
    step();
    step();
    checking = 1'b1;
    chk("rst_WRdy1", WRdy1, 1);
    chk("rst_WLoad2", WLoad2, 0);
    chk("rst_COUNT", COUNT, 0);
    chk("rst_WDATA2", WDATA2, 0);
    chk("rst_ROW_ERR", ROW_ERR, 0);
    RST = 1'b0;

    // Pass-through, one-cycle latency
    WRdy2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(pass_d[i], i);
      step();
      chk("pass_data", WDATA2, pass_d[i]);
      chk("pass_row", WROW2, i);
      chk("pass_count", COUNT, 1);
    end
    WLoad1 = 1'b0;
    step();
    chk("pass_empty", WLoad2, 0);

    // Fill and stall
    WRdy2 = 1'b0;
    base = pushes;
    for (int c = 0; c < 5; c++) begin
      drive(32'hA0 + 32'(pushes - base), (pushes - base) % ROWS);
      step();
    end
    chk("full_WRdy1", WRdy1, 0);
    chk("full_COUNT", COUNT, 4);
    chk("full_head", WDATA2, 32'hA0);
    WRdy2 = 1'b1;
    for (int c = 0; c < 10 && (pushes - base) < 5; c++) begin
      drive(32'hA0 + 32'(pushes - base), (pushes - base) % ROWS);
      step();
    end
    chk("fill_fifth_taken", pushes - base, 5);
    WLoad1 = 1'b0;
    for (int c = 0; c < 8; c++) step();
    chk("drain_empty", WLoad2, 0);

    // Simultaneous push/pop at COUNT=2 across wrap
    WRdy2 = 1'b0;
    base = pushes;
    for (int c = 0; c < 6 && (pushes - base) < 2; c++) begin
      drive(32'hB0 + 32'(pushes - base), m_exp);
      step();
    end
    WRdy2 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive(32'hC0 + 32'(c), m_exp);
      step();
      chk("steady_COUNT", COUNT, 2);
    end
    WLoad1 = 1'b0;
    for (int c = 0; c < 4; c++) step();
    chk("steady_ROW_ERR", ROW_ERR, 0);

    // Row error: rows 0,1,3,0
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'hD0 + 32'(i), rows_e[i]);
      step();
      if (i == 1) chk("rowerr_before", ROW_ERR, 0);
      if (i == 2) chk("rowerr_set", ROW_ERR, 1);
    end
    WLoad1 = 1'b0;
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("rowerr_after_flush", ROW_ERR, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rowerr_after_rst", ROW_ERR, 0);

    // Flush mid-operation with a push in the flush cycle
    WRdy2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'hE0 + 32'(i), i);
      step();
    end
    chk("flush_pre_COUNT", COUNT, 3);
    drive(32'hEE, 1);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("flush_COUNT", COUNT, 0);
    chk("flush_WLoad2", WLoad2, 0);
    chk("flush_WDATA2", WDATA2, 0);
    drive(32'hF0, 0);
    step();
    chk("flush_exp_row", ROW_ERR, 0);
    chk("flush_new_head", WDATA2, 32'hF0);

    // Backpressure hold with pushes ongoing
    sd = WDATA2;
    ss = shamt2;
    sr = WROW2;
    for (int c = 0; c < 5; c++) begin
      drive(32'h100 + 32'(c), m_exp);
      step();
      chk("hold_WDATA2", WDATA2, sd);
      chk("hold_shamt2", shamt2, ss);
      chk("hold_WROW2", WROW2, sr);
    end
    WLoad1 = 1'b0;

    // Random traffic, in-sequence rows
    for (int c = 0; c < 400; c++) begin
      WRdy2 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) drive($urandom, m_exp);
      else WLoad1 = 1'b0;
      step();
    end
    chk("rand_no_row_err", ROW_ERR, 0);

    // Random traffic with bad rows, flushes and resets
    for (int c = 0; c < 600; c++) begin
      WRdy2 = ($urandom_range(0, 2) != 0);
      FLUSH = ($urandom_range(0, 19) == 0);
      RST   = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) != 0)
        drive($urandom, ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : m_exp);
      else
        WLoad1 = 1'b0;
      step();
    end
    RST = 1'b0;
    FLUSH = 1'b0;
    WLoad1 = 1'b0;
    step();
    checking = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
